// File: rtl/frame_draw_controller.sv
// Frame/sprite draw sequencer for the VGA pixel-write port.
// Background sweep with lookup-latency alignment, clipped sprite fill.
module frame_draw_controller #(
   parameter int X_MAX    = 320,
   parameter int Y_MAX    = 240,
   parameter int SPRITE_W = 8,
   parameter int SPRITE_H = 8,
   parameter int COORD_W  = 9
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start_frame,
   input  logic               sprite_req,
   input  logic [COORD_W-1:0] sprite_x,
   input  logic [COORD_W-1:0] sprite_y,
   input  logic [2:0]         sprite_colour,
   output logic [COORD_W-1:0] bg_x,
   output logic [COORD_W-1:0] bg_y,
   input  logic [2:0]         bg_colour,
   output logic [COORD_W-1:0] vga_x,
   output logic [COORD_W-1:0] vga_y,
   output logic [2:0]         vga_colour,
   output logic               vga_plot,
   output logic               sprite_ack,
   output logic               busy,
   output logic               frame_done
);

   localparam int DW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int DH = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int SW = COORD_W + 1;

   localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);
   localparam logic [SW-1:0]      XL = SW'(X_MAX);
   localparam logic [SW-1:0]      YL = SW'(Y_MAX);
   localparam logic [DW-1:0]      DXL = DW'(SPRITE_W - 1);
   localparam logic [DH-1:0]      DYL = DH'(SPRITE_H - 1);

   typedef enum logic [2:0] {
      IDLE,
      BG_SCAN,
      BG_FLUSH,
      BG_DONE,
      SPR_SCAN
   } state_t;

   state_t             state;
   logic [COORD_W-1:0] sx;
   logic [COORD_W-1:0] sy;
   logic [2:0]         scol;
   logic [DW-1:0]      dx;
   logic [DH-1:0]      dy;
   logic               spr_end;
   logic               bg_sel;
   logic [SW-1:0]      sum_x;
   logic [SW-1:0]      sum_y;
   logic               clip;

   // Background colour arrives one cycle late, so it is passed straight
   // through while the background path owns the write port.
   assign vga_colour = bg_sel ? bg_colour : scol;

   // Sprite pixel position, one bit wider so wrap-around cannot hide a clip.
   always_comb begin
      sum_x = {1'b0, sx} + SW'(dx);
      sum_y = {1'b0, sy} + SW'(dy);
      clip  = (sum_x > XL) || (sum_y > YL);
   end

   // Sequencer: arbitration, background sweep, sprite fill.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         bg_x       <= '0;
         bg_y       <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_plot   <= 1'b0;
         sprite_ack <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         sx         <= '0;
         sy         <= '0;
         scol       <= '0;
         dx         <= '0;
         dy         <= '0;
         spr_end    <= 1'b0;
         bg_sel     <= 1'b0;
      end else begin
         sprite_ack <= 1'b0;
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               vga_plot <= 1'b0;
               if (start_frame) begin
                  state  <= BG_SCAN;
                  busy   <= 1'b1;
                  bg_x   <= '0;
                  bg_y   <= '0;
                  bg_sel <= 1'b1;
               end else if (sprite_req) begin
                  state      <= SPR_SCAN;
                  busy       <= 1'b1;
                  sprite_ack <= 1'b1;
                  sx         <= sprite_x;
                  sy         <= sprite_y;
                  scol       <= sprite_colour;
                  dx         <= '0;
                  dy         <= '0;
                  spr_end    <= 1'b0;
                  bg_sel     <= 1'b0;
               end
            end
            BG_SCAN: begin
               vga_x    <= bg_x;
               vga_y    <= bg_y;
               vga_plot <= 1'b1;
               if (bg_x == XM) begin
                  if (bg_y == YM) begin
                     state <= BG_FLUSH;
                  end else begin
                     bg_x <= '0;
                     bg_y <= bg_y + COORD_W'(1);
                  end
               end else begin
                  bg_x <= bg_x + COORD_W'(1);
               end
            end
            BG_FLUSH: begin
               vga_plot   <= 1'b0;
               frame_done <= 1'b1;
               state      <= BG_DONE;
            end
            BG_DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            SPR_SCAN: begin
               if (spr_end) begin
                  vga_plot <= 1'b0;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end else begin
                  vga_x    <= sum_x[COORD_W-1:0];
                  vga_y    <= sum_y[COORD_W-1:0];
                  vga_plot <= ~clip;
                  if (dx == DXL) begin
                     dx <= '0;
                     if (dy == DYL) spr_end <= 1'b1;
                     else dy <= dy + DH'(1);
                  end else begin
                     dx <= dx + DW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_draw_controller.sv
// Bench for frame_draw_controller: per-cycle schedule model,
// directed frame/sprite/clip/reset cases plus random sprite traffic.
module tb_frame_draw_controller;

   localparam int XM = 21;
   localparam int YM = 13;
   localparam int SWD = 8;
   localparam int SHT = 8;
   localparam int CW = 9;

   logic          clock = 1'b0;
   logic          reset;
   logic          start_frame;
   logic          sprite_req;
   logic [CW-1:0] sprite_x;
   logic [CW-1:0] sprite_y;
   logic [2:0]    sprite_colour;
   logic [CW-1:0] bg_x;
   logic [CW-1:0] bg_y;
   logic [2:0]    bg_colour = 3'd0;
   logic [CW-1:0] vga_x;
   logic [CW-1:0] vga_y;
   logic [2:0]    vga_colour;
   logic          vga_plot;
   logic          sprite_ack;
   logic          busy;
   logic          frame_done;

   frame_draw_controller #(
      .X_MAX(XM), .Y_MAX(YM),
      .SPRITE_W(SWD), .SPRITE_H(SHT),
      .COORD_W(CW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start_frame(start_frame),
      .sprite_req(sprite_req),
      .sprite_x(sprite_x),
      .sprite_y(sprite_y),
      .sprite_colour(sprite_colour),
      .bg_x(bg_x),
      .bg_y(bg_y),
      .bg_colour(bg_colour),
      .vga_x(vga_x),
      .vga_y(vga_y),
      .vga_colour(vga_colour),
      .vga_plot(vga_plot),
      .sprite_ack(sprite_ack),
      .busy(busy),
      .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   // Registered background lookup stub: colour is x[2:0].
   always @(posedge clock) bg_colour <= bg_x[2:0];

   typedef struct {
      bit rst;
      bit busy;
      bit plot;
      bit done;
      bit ack;
      int x;
      int y;
      int c;
   } rec_t;

   rec_t q[$];
   rec_t cur;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   dut_plots = 0;
   int   dut_dones = 0;
   int   dut_acks = 0;
   int   busy_cnt = 0;
   int   first_plot = -1;
   int   done_cyc = -1;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   function automatic rec_t mk(bit b, bit p, bit d, bit a,
                               int x, int y, int c);
      rec_t r;
      r.rst = 1'b0;
      r.busy = b;
      r.plot = p;
      r.done = d;
      r.ack = a;
      r.x = x;
      r.y = y;
      r.c = c;
      return r;
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // Model: a request accepted while idle expands into its whole
   // cycle-by-cycle output schedule; one entry is consumed per cycle.
   always @(posedge clock) begin
      if (reset) begin
         q.delete();
         cur = mk(0, 0, 0, 0, 0, 0, 0);
         cur.rst = 1'b1;
      end else begin
         if (!cur.busy && q.size() == 0) begin
            if (start_frame) begin
               q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
               for (int y = 0; y <= YM; y++)
                  for (int x = 0; x <= XM; x++)
                     q.push_back(mk(1, 1, 0, 0, x, y, x % 8));
               q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
            end else if (sprite_req) begin
               int sx, sy, sc;
               sx = int'(sprite_x);
               sy = int'(sprite_y);
               sc = int'(sprite_colour);
               q.push_back(mk(1, 0, 0, 1, 0, 0, 0));
               for (int dy = 0; dy < SHT; dy++)
                  for (int dx = 0; dx < SWD; dx++)
                     q.push_back(mk(1,
                        (sx + dx <= XM) && (sy + dy <= YM),
                        0, 0, sx + dx, sy + dy, sc));
            end
         end
         if (q.size() != 0) cur = q.pop_front();
         else cur = mk(0, 0, 0, 0, 0, 0, 0);
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clock) begin
      if (cyc > 0) begin
         check("busy", busy, cur.busy);
         check("vga_plot", vga_plot, cur.plot);
         check("frame_done", frame_done, cur.done);
         check("sprite_ack", sprite_ack, cur.ack);
         if (cur.rst) begin
            check("rst_vga_x", vga_x, 0);
            check("rst_vga_y", vga_y, 0);
            check("rst_colour", vga_colour, 0);
            check("rst_bg_x", bg_x, 0);
            check("rst_bg_y", bg_y, 0);
         end
         if (cur.plot && vga_plot) begin
            check("vga_x", vga_x, cur.x);
            check("vga_y", vga_y, cur.y);
            check("vga_colour", vga_colour, cur.c);
         end
         if (vga_plot) begin
            dut_plots++;
            if (first_plot < 0) first_plot = cyc;
         end
         if (frame_done) begin
            dut_dones++;
            done_cyc = cyc;
         end
         if (sprite_ack) dut_acks++;
         if (busy) busy_cnt++;
      end
   end

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      @(posedge clock);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_timeout", ok, 1);
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ack();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (sprite_ack) begin
            ok = 1'b1;
            break;
         end
      end
      check("ack_timeout", ok, 1);
      @(posedge clock);
      #1;
      sprite_req = 1'b0;
   endtask

   task automatic sprite(int x, int y, int c, bit wf);
      sprite_x = CW'(x);
      sprite_y = CW'(y);
      sprite_colour = 3'(c);
      sprite_req = 1'b1;
      start_frame = wf;
      @(posedge clock);
      #1;
      start_frame = 1'b0;
      wait_ack();
      wait_idle();
   endtask

   int p0, d0, a0, b0, t0;

   initial begin
      reset = 1'b1;
      start_frame = 1'b0;
      sprite_req = 1'b0;
      sprite_x = '0;
      sprite_y = '0;
      sprite_colour = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // Full frame: 22*14 = 308 plots, first at +2, done at +310.
      p0 = dut_plots;
      d0 = dut_dones;
      first_plot = -1;
      t0 = cyc;
      start_frame = 1'b1;
      @(posedge clock);
      #1;
      start_frame = 1'b0;
      wait_idle();
      check("frame_plots", dut_plots - p0, 308);
      check("first_plot_lat", first_plot - t0, 2);
      check("done_lat", done_cyc - t0, 310);
      check("frame_dones", dut_dones - d0, 1);

      // Unclipped sprite: 64 plots, 65 busy cycles.
      p0 = dut_plots;
      a0 = dut_acks;
      b0 = busy_cnt;
      sprite(2, 3, 5, 1'b0);
      check("spr_plots", dut_plots - p0, 64);
      check("spr_acks", dut_acks - a0, 1);
      check("spr_busy", busy_cnt - b0, 65);

      // Clipped sprite at (18,10): 4*4 plots, same duration.
      p0 = dut_plots;
      b0 = busy_cnt;
      sprite(XM - 3, YM - 3, 6, 1'b0);
      check("clip_plots", dut_plots - p0, 16);
      check("clip_busy", busy_cnt - b0, 65);

      // Frame and sprite together, extra start pulse mid-frame.
      p0 = dut_plots;
      d0 = dut_dones;
      a0 = dut_acks;
      sprite_x = CW'(7);
      sprite_y = CW'(1);
      sprite_colour = 3'd3;
      sprite_req = 1'b1;
      start_frame = 1'b1;
      @(posedge clock);
      #1;
      start_frame = 1'b0;
      repeat (50) @(posedge clock);
      #1;
      start_frame = 1'b1;
      @(posedge clock);
      #1;
      start_frame = 1'b0;
      wait_ack();
      wait_idle();
      check("both_plots", dut_plots - p0, 372);
      check("both_dones", dut_dones - d0, 1);
      check("both_acks", dut_acks - a0, 1);

      // Reset while pixel (10,5) is on bg_x/bg_y.
      d0 = dut_dones;
      start_frame = 1'b1;
      @(posedge clock);
      #1;
      start_frame = 1'b0;
      repeat (120) @(posedge clock);
      #1;
      check("pre_rst_bg_x", bg_x, 10);
      check("pre_rst_bg_y", bg_y, 5);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("rst_no_done", dut_dones - d0, 0);
      p0 = dut_plots;
      start_frame = 1'b1;
      @(posedge clock);
      #1;
      start_frame = 1'b0;
      wait_idle();
      check("restart_plots", dut_plots - p0, 308);
      check("restart_dones", dut_dones - d0, 1);

      // Random sprite traffic, occasionally paired with a frame.
      for (int n = 0; n < 14; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clock);
         #1;
         sprite($urandom_range(0, XM + 8),
                $urandom_range(0, YM + 8),
                $urandom_range(0, 7),
                $urandom_range(0, 4) == 0);
      end

      repeat (3) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_draw_controller.md
Name: frame_draw_controller

Overview:
- Sequences the static background renderer and one sprite layer onto the VGA adapter's pixel-write port.
- Full-frame redraw: sweeps every coordinate through the background lookup, then writes the returned colour to the adapter, compensating for the lookup's one-cycle registered latency.
- Sprite redraw: paints a rectangular sprite (robot) at a requested position.
- Arbitrates the single write port between frame and sprite requests.

Parameters:
- X_MAX, 320, last x coordinate scanned (inclusive).
- Y_MAX, 240, last y coordinate scanned (inclusive).
- SPRITE_W, 8, sprite width in pixels.
- SPRITE_H, 8, sprite height in pixels.
- COORD_W, 9, coordinate width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_frame  in  1  one-cycle pulse requesting a full background redraw.
- sprite_req  in  1  level request for a sprite draw; held high until sprite_ack.
- sprite_x  in  COORD_W  sprite top-left x, sampled at acceptance.
- sprite_y  in  COORD_W  sprite top-left y, sampled at acceptance.
- sprite_colour  in  3  sprite colour, sampled at acceptance.
- bg_x  out  COORD_W  coordinate to background lookup.
- bg_y  out  COORD_W  coordinate to background lookup.
- bg_colour  in  3  background colour; valid one cycle after bg_x/bg_y are presented.
- vga_x  out  COORD_W  pixel write x.
- vga_y  out  COORD_W  pixel write y.
- vga_colour  out  3  pixel write colour.
- vga_plot  out  1  pixel write enable.
- sprite_ack  out  1  one-cycle pulse when a sprite request is accepted.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last background pixel is plotted.

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state=IDLE; counters=0.
  - vga_plot, sprite_ack, busy, frame_done all 0.
  - bg_x, bg_y, vga_x, vga_y, vga_colour all 0.
  - Reset mid-scan abandons the scan and issues no frame_done.
- States: IDLE, BG_SCAN, BG_FLUSH, BG_DONE, SPR_SCAN.
- IDLE arbitration:
  - start_frame takes priority over sprite_req.
  - If both are high, go to BG_SCAN; the sprite request stays pending because sprite_req remains high, and is served on return to IDLE.
  - sprite_req alone: pulse sprite_ack, latch sprite_x/y/colour, go to SPR_SCAN.
- start_frame while busy is ignored, not queued. sprite_req while busy waits.
- BG_SCAN:
  - Counter (cx,cy) drives bg_x/bg_y, starting at (0,0).
  - x is the fast index: cx 0..X_MAX, then cx=0 and cy+1.
  - At (X_MAX,Y_MAX), go to BG_FLUSH.
  - A delay register captures (cx,cy,valid) every cycle.
  - vga_x/vga_y come from the delay register; vga_colour=bg_colour; vga_plot=delayed valid.
  - Result: pixel (x,y) is plotted exactly one cycle after it appears on bg_x/bg_y.
- BG_FLUSH: one cycle; plots the final pixel (X_MAX,Y_MAX), then goes to BG_DONE.
- BG_DONE: frame_done=1 for one cycle, vga_plot=0, then IDLE.
- Background timing totals:
  - Plot count: (X_MAX+1)*(Y_MAX+1) = 77361 with defaults.
  - start_frame accepted at cycle 0 → first plot at cycle 2, last plot at cycle 77362, frame_done at cycle 77363.
- SPR_SCAN:
  - Offsets (dx,dy) start at (0,0); dx is the fast index, 0..SPRITE_W-1.
  - Writes are registered: vga_x=sx+dx, vga_y=sy+dy, vga_colour=latched colour, vga_plot=1, one cycle after each offset.
  - Sums are computed at COORD_W+1 bits.
  - Any pixel with sum x>X_MAX or y>Y_MAX is clipped: vga_plot=0, but the offset still advances (fixed duration).
  - After offset (SPRITE_W-1,SPRITE_H-1), return to IDLE on the next cycle, after the last write.
  - Duration: SPRITE_W*SPRITE_H write cycles.
  - bg_x/bg_y hold their last value during SPR_SCAN.
- In IDLE, vga_plot=0 and the vga_* coordinates hold.
- At most one write per cycle; busy is deasserted on the cycle the state returns to IDLE.

Test Plan:
- Reset then one-cycle start_frame → vga_plot high for exactly 77361 cycles, raster order (0,0),(1,0)…(320,0),(0,1)…(320,240); each vga_colour equals the background model's colour for that pixel; one frame_done pulse; busy high throughout.
- Latency alignment: background stub returns a colour derived from bg_x[2:0] → at every plot, vga_colour equals vga_x[2:0].
- sprite_req with (100,50), colour 3'b101 → one sprite_ack; 64 plots covering x 100..107, y 50..57, all colour 5; busy low afterwards.
- Clipping: sprite at (316,236) → only 5×5=25 plots, at x 316..320, y 236..240; total duration is still 64 write cycles.
- start_frame and sprite_req asserted together → full frame first, frame_done, then sprite_ack and the sprite draw; a start_frame pulse mid-frame is ignored (exactly one frame_done).
- Reset asserted at pixel (150,100) mid-scan → next cycle vga_plot=0, busy=0, no frame_done; a new start_frame restarts at (0,0).
